// File: rtl/multicycle_divider_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_divider_pkg
//   Shared definitions for the RV32M iterative divider: operand width,
//   iteration-counter width, M-extension decode constants, divide op codes
//   (funct3[1:0]) and the divider FSM state encoding.
// ---------------------------------------------------------------------------
package multicycle_divider_pkg;

  localparam int DIV_XLEN = 32;
  localparam int DIV_CNTW = $clog2(DIV_XLEN) + 1;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3[1:0] of the M-extension divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Decode helper for the stage that generates div_valid.
  function automatic logic is_div_instr(input logic [6:0] opcode,
                                        input logic [6:0] funct7,
                                        input logic [2:0] funct3);
    return (opcode == OPC_OP) && (funct7 == F7_MULDIV) && funct3[2];
  endfunction

  // DIV and REM are the signed flavours (funct3[0] == 0).
  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/multicycle_divider_div_step.sv
// ---------------------------------------------------------------------------
// multicycle_divider_div_step
//   One combinational radix-2 restoring division iteration on magnitudes.
//   The dividend is shifted out of the top of q while quotient bits are
//   shifted into its bottom, so q ends up holding the quotient.
// Ports
//   rem      in  XLEN  partial remainder (always < divisor)
//   q        in  XLEN  remaining dividend bits / quotient so far
//   divisor  in  XLEN  divisor magnitude
//   rem_next out XLEN  partial remainder after this step
//   q_next   out XLEN  q shifted left with the new quotient bit
// ---------------------------------------------------------------------------
module multicycle_divider_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] q_next
);

  // One extra bit so the trial subtract's sign is visible; the shifted
  // remainder can reach 2*divisor-1, which needs XLEN+1 bits.
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // NOTE: every output of a combinational block gets a value on every path;
  // a path that leaves one unassigned makes synthesis infer a latch.
  always_comb begin
    shifted = {rem, q[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      q_next   = {q[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      q_next   = {q[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multicycle_divider.sv
// ---------------------------------------------------------------------------
// multicycle_divider
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, sitting
//   in EX beside the ALU. Stalls F/D/E while an operation is in flight and
//   presents the sign-corrected result in the cycle the stall releases.
// Ports
//   clk          in   1     clock, rising edge
//   rst          in   1     asynchronous active-high reset
//   div_valid    in   1     EX holds a valid M-ext divide instruction
//   div_op       in   2     funct3[1:0]: DIV, DIVU, REM, REMU
//   flush        in   1     EX instruction killed; aborts the operation
//   hold         in   1     memory stall; pipeline frozen, result persists
//   src_a        in   XLEN  dividend
//   src_b        in   XLEN  divisor
//   div_stalled  out  1     stall request to the hazard unit
//   result       out  XLEN  quotient or remainder, sign-corrected
//   result_valid out  1     result is final this cycle
// ---------------------------------------------------------------------------
module multicycle_divider
  import multicycle_divider_pkg::*;
#(
  parameter int XLEN = DIV_XLEN,
  parameter int CNTW = DIV_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  input  logic [1:0]      div_op,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            div_stalled,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_next;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] quo;      // dividend on entry, quotient on exit
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  div_op_e         op;
  logic            sign_a;
  logic            sign_b;

  // Operand preparation, only consumed on the accepting IDLE edge.
  div_op_e         op_in;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, overflow, start;

  logic [XLEN-1:0] rem_step, quo_step;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    op_in    = div_op_e'(div_op);
    a_neg    = op_is_signed(op_in) & src_a[XLEN-1];
    b_neg    = op_is_signed(op_in) & src_b[XLEN-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    div_zero = (src_b == '0);
    overflow = op_is_signed(op_in) && (src_a == MIN_NEG) && (src_b == '1);
    start    = div_valid & ~flush & ~hold;
  end

  multicycle_divider_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .q        (quo),
    .divisor  (dvs),
    .rem_next (rem_step),
    .q_next   (quo_step)
  );

  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    div_stalled  = 1'b0;
    result_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        // Stall in the very cycle the divide shows up in EX.
        div_stalled = div_valid & ~flush;
        if (start) state_next = (div_zero | overflow) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        div_stalled = ~flush;
        if (flush)                   state_next = ST_IDLE;
        else if (cnt == CNTW'(1))    state_next = ST_DONE;
      end
      ST_DONE: begin
        result_valid = ~flush;
        if (flush || !hold) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath. Special cases preload the final quotient/remainder with the
  // sign flags cleared, so DONE needs no separate special-result path.
  // NOTE: every datapath register is reset, not just the FSM, so a reset
  // in any state leaves result reading zero and no stale operands behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      op     <= OP_DIV;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op <= op_in;
            if (div_zero) begin
              quo    <= '1;
              rem    <= src_a;
              dvs    <= '0;
              cnt    <= '0;
              sign_a <= 1'b0;
              sign_b <= 1'b0;
            end else if (overflow) begin
              quo    <= MIN_NEG;
              rem    <= '0;
              dvs    <= '0;
              cnt    <= '0;
              sign_a <= 1'b0;
              sign_b <= 1'b0;
            end else begin
              quo    <= a_mag;
              rem    <= '0;
              dvs    <= b_mag;
              cnt    <= CNTW'(XLEN);
              sign_a <= a_neg;
              sign_b <= b_neg;
            end
          end
        end
        ST_BUSY: begin
          quo <= quo_step;
          rem <= rem_step;
          cnt <= cnt - CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  // Quotient is negative when operand signs differ; the remainder takes
  // the dividend's sign (truncating division).
  always_comb begin
    quo_fix = (sign_a ^ sign_b) ? -quo : quo;
    rem_fix = sign_a ? -rem : rem;
    result  = '0;
    if (state == ST_DONE) result = op_is_rem(op) ? rem_fix : quo_fix;
  end

endmodule
